// File: rtl/wb_trace_fifo.sv
// Write-back trace buffer: queues retired GRF and DM writes for the bench.
// FWFT valid/ready output, two pushes and one pop per edge, overflow counted.
module wb_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wdata,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              dropped
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        grf_e;
    entry_t        dm_e;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW-1:0] wptr1;
    logic [AW+1:0] free;
    logic          grf_c;
    logic          dm_c;
    logic          pop;
    logic          grf_push;
    logic          dm_push;
    logic [1:0]    npush;
    logic [1:0]    ndrop;
    logic [16:0]   dsum;

    always_comb begin
        grf_c    = grf_we && (grf_addr != 5'd0);
        dm_c     = dm_we;
        pop      = out_valid && out_ready;
        // a pop on this edge frees a slot the pushes may reuse
        free     = (AW+2)'(DEPTH) - {1'b0, count}
                 + {{(AW+1){1'b0}}, pop};
        grf_push = grf_c && (free != '0);
        if (grf_push)
            dm_push = dm_c && (free >= (AW+2)'(2));
        else
            dm_push = dm_c && (free >= (AW+2)'(1));
        npush    = {1'b0, grf_push} + {1'b0, dm_push};
        ndrop    = {1'b0, grf_c & ~grf_push}
                 + {1'b0, dm_c & ~dm_push};
        dsum     = {1'b0, dropped} + {15'b0, ndrop};
        wptr1    = wptr + AW'(grf_push);
        grf_e    = '{kind: 1'b0, pc: grf_pc,
                     addr: {27'b0, grf_addr}, data: grf_wdata};
        dm_e     = '{kind: 1'b1, pc: dm_pc,
                     addr: dm_addr, data: dm_wdata};
    end

    always_comb begin
        head      = mem[rptr];
        out_valid = (count != '0);
        out_kind  = out_valid ? head.kind : 1'b0;
        out_pc    = out_valid ? head.pc   : 32'b0;
        out_addr  = out_valid ? head.addr : 32'b0;
        out_data  = out_valid ? head.data : 32'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= 16'h0;
        end else begin
            if (pop)
                rptr <= rptr + AW'(1);
            wptr  <= wptr + AW'(npush);
            count <= count + (AW+1)'(npush) - (AW+1)'(pop);
            if (ndrop != 2'd0) begin
                overflow <= 1'b1;
                dropped  <= dsum[16] ? 16'hFFFF : dsum[15:0];
            end
        end
    end

    // GRF lands first, so DM takes the following slot
    always_ff @(posedge clk) begin
        if (grf_push)
            mem[wptr] <= grf_e;
        if (dm_push)
            mem[wptr1] <= dm_e;
    end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with a queue scoreboard and
// an independent monitor that checks every accepted head entry.
module tb_wb_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] dropped;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    wb_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc),
        .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_pc(out_pc),
        .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(input logic k,
                                      input logic [31:0] p,
                                      input logic [31:0] a,
                                      input logic [31:0] d);
        ev_t e;
        e = '{kind: k, pc: p, addr: a, data: d};
        exp_q.push_back(e);
    endfunction

    task automatic set_grf(input logic [31:0] p,
                           input logic [4:0] a,
                           input logic [31:0] d);
        grf_we = 1'b1; grf_pc = p; grf_addr = a; grf_wdata = d;
    endtask

    task automatic set_dm(input logic [31:0] p,
                          input logic [31:0] a,
                          input logic [31:0] d);
        dm_we = 1'b1; dm_pc = p; dm_addr = a; dm_wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        grf_we = 1'b0;
        dm_we  = 1'b0;
    endtask

    // monitor: the entry visible while ready is high is consumed next edge
    always @(negedge clk) begin
        ev_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_extra: got pc %h want none", out_pc);
            end else begin
                e = exp_q.pop_front();
                if ({out_kind, out_pc, out_addr, out_data} !== e) begin
                    errors++;
                    $display("FAIL mon_head: got %h %h %h %h want %h %h %h %h",
                             out_kind, out_pc, out_addr, out_data,
                             e.kind, e.pc, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wdata = '0;
        dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_pc", out_pc, 32'd0);

        set_grf(32'h3000, 5'd5, 32'h1234);
        expect_ev(1'b0, 32'h3000, 32'd5, 32'h1234);
        step();
        chk("g1_valid", 32'(out_valid), 32'd1);
        chk("g1_kind", 32'(out_kind), 32'd0);
        chk("g1_addr", out_addr, 32'h5);
        chk("g1_count", 32'(count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", out_pc, 32'h3000);
            chk("hold_data", out_data, 32'h1234);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop1_count", 32'(count), 32'd0);
        chk("pop1_valid", 32'(out_valid), 32'd0);
        chk("pop1_pc", out_pc, 32'd0);
        chk("pop1_addr", out_addr, 32'd0);
        chk("pop1_data", out_data, 32'd0);

        set_grf(32'h3100, 5'd0, 32'h55);
        step();
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_dropped", 32'(dropped), 32'd0);

        set_grf(32'h3004, 5'd8, 32'hA);
        set_dm(32'h3004, 32'h10, 32'hB);
        expect_ev(1'b0, 32'h3004, 32'd8, 32'hA);
        expect_ev(1'b1, 32'h3004, 32'h10, 32'hB);
        step();
        chk("dual_count", 32'(count), 32'd2);
        chk("dual_kind", 32'(out_kind), 32'd0);
        out_ready = 1'b1;
        step();
        chk("dual_kind2", 32'(out_kind), 32'd1);
        step();
        out_ready = 1'b0;
        chk("dual_empty", 32'(count), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            set_dm(32'h4000 + 32'(4 * i), 32'h100 + 32'(4 * i),
                   32'(i + 1));
            expect_ev(1'b1, 32'h4000 + 32'(4 * i),
                      32'h100 + 32'(4 * i), 32'(i + 1));
            step();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_overflow", 32'(overflow), 32'd0);
        set_dm(32'h5000, 32'h500, 32'hDEAD);
        step();
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_dropped", 32'(dropped), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", out_pc, 32'h4000);

        out_ready = 1'b1;
        set_grf(32'h6000, 5'd9, 32'h99);
        set_dm(32'h6004, 32'h200, 32'h77);
        expect_ev(1'b0, 32'h6000, 32'd9, 32'h99);
        step();
        chk("fp_count", 32'(count), 32'd16);
        chk("fp_dropped", 32'(dropped), 32'd2);
        for (int i = 0; i < DEPTH; i++)
            step();
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 5; i++) begin
            set_grf(32'h7000 + 32'(4 * i), 5'(i + 1), 32'(i));
            expect_ev(1'b0, 32'h7000 + 32'(4 * i), 32'(i + 1), 32'(i));
            step();
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_dropped", 32'(dropped), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        exp_q.delete();
        reset = 1'b0;
        set_grf(32'h8000, 5'd3, 32'h33);
        expect_ev(1'b0, 32'h8000, 32'd3, 32'h33);
        step();
        chk("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(count), 32'd0);

        for (int i = 0; i < 20; i++) begin
            set_dm(32'h9000 + 32'(4 * i), 32'h300 + 32'(4 * i),
                   32'h1000 + 32'(i));
            expect_ev(1'b1, 32'h9000 + 32'(4 * i),
                      32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
            step();
            chk("stream_count", 32'(count), 32'd1);
        end
        step();
        out_ready = 1'b0;
        chk("stream_empty", 32'(count), 32'd0);
        chk("stream_dropped", 32'(dropped), 32'd0);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
